rr_bus_arbiter: RTL and testbench

- Parametrised N-requester round-robin bus arbiter; successor to the two-master alternating arbiter.
- Grants bus ownership to one requester at a time, with registered one-hot grant and encoded owner ID.
- The owner keeps the bus while it holds its request; an optional hold limit forces rotation when others wait.
- Sits between bus masters and the shared-bus mux; grant_id drives the mux select.

---
 rtl/rr_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// N-requester round-robin bus arbiter with registered one-hot grant, owner ID
// and an optional hold limit that forces rotation while other masters wait.
module rr_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int ID_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid
);

    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_ONE = HC_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [N-1:0]    grant_r, grant_s;
    logic [ID_W-1:0] grant_id_r, grant_id_s;
    logic            valid_r, valid_s;
    logic [HC_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [ID_W-1:0] last_id_r, last_id_s;

    logic [N-1:0]    others_s;
    logic [ID_W:0]   pick_idle_s;
    logic [ID_W:0]   pick_own_s;

    // Returns {found, index} of the first set bit strictly after p, wrapping mod N.
    function automatic logic [ID_W:0] pick_after(input logic [N-1:0] r, input logic [ID_W-1:0] p);
        logic            found;
        logic [ID_W-1:0] win;
        logic [N-1:0]    sh;
        int              idx;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(p) + k) % N;
            sh  = r >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        return {found, win};
    endfunction

    function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] id);
        return {{(N-1){1'b0}}, 1'b1} << id;
    endfunction

    // State, grant and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            grant_id_r <= '0;
            valid_r    <= 1'b0;
            hold_cnt_r <= '0;
            last_id_r  <= ID_W'(N - 1);
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            grant_id_r <= grant_id_s;
            valid_r    <= valid_s;
            hold_cnt_r <= hold_cnt_s;
            last_id_r  <= last_id_s;
        end
    end

    // Next-state and arbitration decision.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        grant_id_s  = grant_id_r;
        valid_s     = valid_r;
        hold_cnt_s  = hold_cnt_r;
        last_id_s   = last_id_r;
        // Release and preemption both pick among requesters other than the owner.
        others_s    = req & ~onehot(grant_id_r);
        pick_idle_s = pick_after(req, last_id_r);
        pick_own_s  = pick_after(others_s, grant_id_r);

        case (state_r)
            IDLE: begin
                if (pick_idle_s[ID_W]) begin
                    state_s    = OWNED;
                    grant_s    = onehot(pick_idle_s[ID_W-1:0]);
                    grant_id_s = pick_idle_s[ID_W-1:0];
                    valid_s    = 1'b1;
                    hold_cnt_s = HOLD_ONE;
                    last_id_s  = pick_idle_s[ID_W-1:0];
                end else begin
                    grant_s    = '0;
                    valid_s    = 1'b0;
                end
            end
            OWNED: begin
                if (!req[grant_id_r] ||
                    ((MAX_HOLD != 0) && (hold_cnt_r == HOLD_MAX) && pick_own_s[ID_W])) begin
                    if (pick_own_s[ID_W]) begin
                        grant_s    = onehot(pick_own_s[ID_W-1:0]);
                        grant_id_s = pick_own_s[ID_W-1:0];
                        valid_s    = 1'b1;
                        hold_cnt_s = HOLD_ONE;
                        last_id_s  = pick_own_s[ID_W-1:0];
                    end else begin
                        state_s    = IDLE;
                        grant_s    = '0;
                        valid_s    = 1'b0;
                        hold_cnt_s = '0;
                    end
                end else begin
                    hold_cnt_s = (hold_cnt_r == HOLD_MAX) ? HOLD_MAX : hold_cnt_r + HOLD_ONE;
                end
            end
            default: begin
                state_s    = IDLE;
                grant_s    = '0;
                valid_s    = 1'b0;
                hold_cnt_s = '0;
            end
        endcase
    end

    assign grant       = grant_r;
    assign grant_id    = grant_id_r;
    assign grant_valid = valid_r;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: N=4/MAX_HOLD=8, N=3 and a MAX_HOLD=0 build.
module tb_rr_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = 4'b0000;
    logic [2:0] req_b = 3'b000;
    logic [3:0] req_c = 4'b0000;

    logic [3:0] grant_a;
    logic [1:0] id_a;
    logic       valid_a;
    logic [2:0] grant_b;
    logic [1:0] id_b;
    logic       valid_b;
    logic [3:0] grant_c;
    logic [1:0] id_c;
    logic       valid_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req_a),
        .grant(grant_a), .grant_id(id_a), .grant_valid(valid_a)
    );

    rr_bus_arbiter #(.N(3), .MAX_HOLD(8)) dut3 (
        .clk(clk), .rst(rst), .req(req_b),
        .grant(grant_b), .grant_id(id_b), .grant_valid(valid_b)
    );

    rr_bus_arbiter #(.N(4), .MAX_HOLD(0)) dut_nh (
        .clk(clk), .rst(rst), .req(req_c),
        .grant(grant_c), .grant_id(id_c), .grant_valid(valid_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req_a = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (grant_a !== 4'b0000 || valid_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: grant=%b valid=%b expected 0000/0", grant_a, valid_a);
            end
        end
        rst   = 1'b0;
        req_a = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (grant_a !== 4'b0000 || valid_a !== 1'b0 || id_a !== 2'd0) begin
                errors++;
                $display("FAIL idle_after_reset: grant=%b valid=%b id=%0d expected 0000/0/0",
                         grant_a, valid_a, id_a);
            end
        end
    endtask

    task automatic test_single();
        req_a = 4'b0100;
        step();
        checks++;
        if (grant_a !== 4'b0100 || id_a !== 2'd2 || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b id=%0d valid=%b expected 0100/2/1",
                     grant_a, id_a, valid_a);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (grant_a !== 4'b0100) begin
                errors++;
                $display("FAIL single_hold cycle %0d: grant=%b expected 0100", i, grant_a);
            end
        end
        req_a = 4'b0000;
        step();
        checks++;
        if (grant_a !== 4'b0000 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL single_release: grant=%b valid=%b expected 0000/0", grant_a, valid_a);
        end
    endtask

    task automatic test_rotation();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_a = 4'b1111;
        step();
        checks++;
        if (grant_a !== 4'b0001 || id_a !== 2'd0) begin
            errors++;
            $display("FAIL rotation_first: grant=%b id=%0d expected 0001/0", grant_a, id_a);
        end
        for (int i = 1; i < 5; i++) begin
            req_a = 4'b1111 & ~(4'b0001 << exp_seq[i-1]);
            step();
            checks++;
            if (grant_a !== (4'b0001 << exp_seq[i]) || id_a !== 2'(exp_seq[i]) || valid_a !== 1'b1) begin
                errors++;
                $display("FAIL rotation step %0d: grant=%b id=%0d valid=%b expected id %0d",
                         i, grant_a, id_a, valid_a, exp_seq[i]);
            end
        end
        req_a = 4'b0000;
        step();
    endtask

    task automatic test_preempt();
        do_reset();
        req_a = 4'b0010;
        step();
        checks++;
        if (grant_a !== 4'b0010) begin
            errors++;
            $display("FAIL preempt_initial: grant=%b expected 0010", grant_a);
        end
        req_a = 4'b1010;
        for (int i = 2; i <= 8; i++) begin
            step();
            checks++;
            if (grant_a !== 4'b0010) begin
                errors++;
                $display("FAIL preempt_owner1 cycle %0d: grant=%b expected 0010", i, grant_a);
            end
        end
        step();
        checks++;
        if (grant_a !== 4'b1000 || id_a !== 2'd3) begin
            errors++;
            $display("FAIL preempt_to3: grant=%b id=%0d expected 1000/3", grant_a, id_a);
        end
        for (int i = 2; i <= 8; i++) begin
            step();
            checks++;
            if (grant_a !== 4'b1000) begin
                errors++;
                $display("FAIL preempt_owner3 cycle %0d: grant=%b expected 1000", i, grant_a);
            end
        end
        step();
        checks++;
        if (grant_a !== 4'b0010 || id_a !== 2'd1) begin
            errors++;
            $display("FAIL preempt_back_to1: grant=%b id=%0d expected 0010/1", grant_a, id_a);
        end
        req_a = 4'b0000;
        step();
    endtask

    task automatic test_no_preempt();
        do_reset();
        req_c = 4'b0010;
        step();
        req_c = 4'b1010;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (grant_c !== 4'b0010 || id_c !== 2'd1) begin
                errors++;
                $display("FAIL no_preempt cycle %0d: grant=%b id=%0d expected 0010/1", i, grant_c, id_c);
            end
        end
        req_c = 4'b1000;
        step();
        checks++;
        if (grant_c !== 4'b1000 || id_c !== 2'd3) begin
            errors++;
            $display("FAIL no_preempt_release: grant=%b id=%0d expected 1000/3", grant_c, id_c);
        end
        req_c = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req_b = 3'b100;
        step();
        checks++;
        if (grant_b !== 3'b100 || id_b !== 2'd2) begin
            errors++;
            $display("FAIL wrap_owner2: grant=%b id=%0d expected 100/2", grant_b, id_b);
        end
        req_b = 3'b011;
        step();
        checks++;
        if (grant_b !== 3'b001 || id_b !== 2'd0 || valid_b !== 1'b1) begin
            errors++;
            $display("FAIL wrap_to0: grant=%b id=%0d valid=%b expected 001/0/1", grant_b, id_b, valid_b);
        end
        req_b = 3'b010;
        step();
        checks++;
        if (grant_b !== 3'b010 || id_b !== 2'd1) begin
            errors++;
            $display("FAIL wrap_to1: grant=%b id=%0d expected 010/1", grant_b, id_b);
        end
        req_b = 3'b000;
        step();
        checks++;
        if (grant_b !== 3'b000 || valid_b !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: grant=%b valid=%b expected 000/0", grant_b, valid_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a = 4'b0100;
        step();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (grant_a !== 4'b0100) begin
            errors++;
            $display("FAIL mid_owner2: grant=%b expected 0100", grant_a);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (grant_a !== 4'b0000 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: grant=%b valid=%b expected 0000/0", grant_a, valid_a);
        end
        req_a = 4'b0110;
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (grant_a !== 4'b0010 || id_a !== 2'd1) begin
            errors++;
            $display("FAIL mid_restart: grant=%b id=%0d expected 0010/1", grant_a, id_a);
        end
        req_a = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_no_preempt();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
